core_ifetch: RTL

- Instruction-fetch stage of the RV32I pipeline, directly upstream of the hazard control unit.
- Owns the PC and runs a single-outstanding read handshake on the instruction-memory bus.
- Buffers the returned word and loads the IF/ID pipeline register under the HCU_PC_WRITE / HCU_IFID_ENABLE / HCU_IFID_FLUSH controls.
- Produces HCU_IMEM_DONE for the HCU and accepts branch/jump redirects from execute.

---
 rtl/core_ifetch.sv | 134 +++++++++++++
 1 files changed

// File: rtl/core_ifetch.sv
// RV32I instruction-fetch stage: owns the PC, runs a single-outstanding read on the
// instruction bus, buffers the returned word and loads the IF/ID register.
//
// state  | meaning
// S_ADDR | read address presented on the bus, waiting for ARREADY
// S_DATA | address accepted, waiting for RVALID
// S_HOLD | fetch buffer holds a word, waiting for permission to advance
module core_ifetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        HCU_PC_WRITE,
  input  logic        HCU_IFID_ENABLE,
  input  logic        HCU_IFID_FLUSH,
  input  logic        REDIRECT_VALID,
  input  logic [31:0] REDIRECT_PC,
  output logic        IMEM_ARVALID,
  input  logic        IMEM_ARREADY,
  output logic [31:0] IMEM_ARADDR,
  input  logic        IMEM_RVALID,
  output logic        IMEM_RREADY,
  input  logic [31:0] IMEM_RDATA,
  output logic        HCU_IMEM_DONE,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_INSTR,
  output logic        IFID_VALID
);

  typedef enum logic [1:0] {S_ADDR, S_DATA, S_HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] req_addr, req_addr_nxt;
  logic [31:0] fetch_buf, fetch_buf_nxt;
  logic        discard, discard_nxt;
  logic        ar_en;
  logic [31:0] redirect_tgt;
  logic [31:0] pc_inc;
  logic        advance;

  assign redirect_tgt  = {REDIRECT_PC[31:2], 2'b00};
  assign pc_inc        = pc + 32'd4;
  // ar_en keeps ARVALID low through reset and for the first cycle it is released
  assign IMEM_ARVALID  = (state == S_ADDR) && ar_en;
  assign IMEM_RREADY   = (state == S_DATA);
  assign HCU_IMEM_DONE = (state == S_HOLD);
  assign IMEM_ARADDR   = req_addr;
  assign advance       = (state == S_HOLD) && HCU_PC_WRITE && HCU_IFID_ENABLE && !REDIRECT_VALID;

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    req_addr_nxt  = req_addr;
    fetch_buf_nxt = fetch_buf;
    discard_nxt   = discard;
    if (REDIRECT_VALID) pc_nxt = redirect_tgt;
    case (state)
      S_ADDR: begin
        if (IMEM_ARVALID && IMEM_ARREADY) begin
          state_nxt = S_DATA;
          if (REDIRECT_VALID) discard_nxt = 1'b1;
        end else if (REDIRECT_VALID) begin
          // an address already on the bus must complete; otherwise retarget freely
          if (IMEM_ARVALID) discard_nxt = 1'b1;
          else req_addr_nxt = redirect_tgt;
        end
      end
      S_DATA: begin
        if (IMEM_RVALID) begin
          if (discard || REDIRECT_VALID) begin
            discard_nxt  = 1'b0;
            state_nxt    = S_ADDR;
            req_addr_nxt = REDIRECT_VALID ? redirect_tgt : pc;
          end else begin
            fetch_buf_nxt = IMEM_RDATA;
            state_nxt     = S_HOLD;
          end
        end else if (REDIRECT_VALID) begin
          discard_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (REDIRECT_VALID) begin
          state_nxt    = S_ADDR;
          req_addr_nxt = redirect_tgt;
        end else if (advance) begin
          pc_nxt       = pc_inc;
          req_addr_nxt = pc_inc;
          state_nxt    = S_ADDR;
        end
      end
      default: state_nxt = S_ADDR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state      <= S_ADDR;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      fetch_buf  <= NOP_INSTR;
      discard    <= 1'b0;
      ar_en      <= 1'b0;
      IFID_PC    <= 32'h0;
      IFID_INSTR <= NOP_INSTR;
      IFID_VALID <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      req_addr  <= req_addr_nxt;
      fetch_buf <= fetch_buf_nxt;
      discard   <= discard_nxt;
      ar_en     <= 1'b1;
      if (HCU_IFID_FLUSH) begin
        IFID_PC    <= 32'h0;
        IFID_INSTR <= NOP_INSTR;
        IFID_VALID <= 1'b0;
      end else if (HCU_IFID_ENABLE) begin
        if (advance) begin
          IFID_PC    <= pc;
          IFID_INSTR <= fetch_buf;
          IFID_VALID <= 1'b1;
        end else begin
          IFID_PC    <= pc;
          IFID_INSTR <= NOP_INSTR;
          IFID_VALID <= 1'b0;
        end
      end
    end
  end

endmodule
